// File: rtl/servant_pkg.sv
// Shared definitions for the servant power sequencer.
// Holds the 3-bit FSM state width and the state encoding.
package servant_pkg;

    localparam int PS_W = 3;

    typedef enum logic [PS_W-1:0] {
        PS_OFF  = 3'd0,
        PS_WAKE = 3'd1,
        PS_ON   = 3'd2,
        PS_IDLE = 3'd3,
        PS_COOL = 3'd4
    } ps_e;

endpackage

// File: rtl/servant_sync2.sv
// Two-flop synchroniser, parameterised width, async active-high reset.
// Ports: i_clk, i_rst, i_d (async input), o_q (synchronised output).
module servant_sync2 #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_s1;
    logic [W-1:0] r_s2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/servant_power_sequencer.sv
// Always-on HF oscillator enable controller running on the slow clock.
// Ports: i_clk, i_rst, i_req, i_force_on in; o_clk_en, o_ready, o_ack,
// o_tick, o_state out (state is debug only).
module servant_power_sequencer
    import servant_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int CNT_W        = 16,
    parameter int WAKE_CYCLES  = 2,
    parameter int IDLE_TIMEOUT = 16,
    parameter int COOL_CYCLES  = 1,
    parameter int PERIOD       = 0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_force_on,
    output logic             o_clk_en,
    output logic             o_ready,
    output logic [N_REQ-1:0] o_ack,
    output logic             o_tick,
    output logic [PS_W-1:0]  o_state
);

    localparam logic [CNT_W-1:0] LP_WAKE = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_IDLE = CNT_W'(IDLE_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LP_COOL = CNT_W'(COOL_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_PMAX =
        CNT_W'((PERIOD == 0) ? 0 : PERIOD - 1);

    logic [N_REQ:0]   w_sync;
    logic [N_REQ-1:0] w_req_s;
    logic             w_force_s;
    logic             w_any;

    ps_e              r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_pcnt;
    logic             r_tick_pend;
    logic             r_clk_en;
    logic             r_ready;
    logic [N_REQ-1:0] r_ack;
    logic             r_tick;

    servant_sync2 #(
        .W (N_REQ + 1)
    ) u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   ({i_force_on, i_req}),
        .o_q   (w_sync)
    );

    assign w_req_s   = w_sync[N_REQ-1:0];
    assign w_force_s = w_sync[N_REQ];
    assign w_any     = (|w_req_s) | w_force_s | r_tick_pend;

    // Main FSM; outputs are registered alongside the next state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= PS_OFF;
            r_cnt    <= '0;
            r_clk_en <= 1'b0;
            r_ready  <= 1'b0;
            r_ack    <= '0;
            r_tick   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            r_ack  <= '0;
            // Saturating countdown; state loads below take priority.
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            unique case (r_state)
                PS_OFF: begin
                    if (w_any) begin
                        r_state  <= PS_WAKE;
                        r_cnt    <= LP_WAKE;
                        r_clk_en <= 1'b1;
                    end
                end
                PS_WAKE: begin
                    if (r_cnt == '0) begin
                        r_state <= PS_ON;
                        r_ready <= 1'b1;
                    end
                end
                PS_ON: begin
                    r_ack <= w_req_s;
                    if (r_tick_pend) begin
                        r_tick <= 1'b1;
                    end
                    if (!w_any) begin
                        r_state <= PS_IDLE;
                        r_cnt   <= LP_IDLE;
                    end
                end
                PS_IDLE: begin
                    if (w_any) begin
                        // Re-entry grants immediately from this cycle's requests.
                        r_state <= PS_ON;
                        r_ack   <= w_req_s;
                    end else if (r_cnt == '0) begin
                        r_state  <= PS_COOL;
                        r_cnt    <= LP_COOL;
                        r_clk_en <= 1'b0;
                        r_ready  <= 1'b0;
                    end
                end
                PS_COOL: begin
                    if (r_cnt == '0) begin
                        r_state <= PS_OFF;
                    end
                end
                default: begin
                    r_state <= PS_OFF;
                end
            endcase
        end
    end

    // Periodic wake timer. A fresh wrap wins over a same-cycle service
    // so that no wrap is ever lost; repeated wraps merge into one pend.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pcnt      <= '0;
            r_tick_pend <= 1'b0;
        end else begin
            if (r_state == PS_ON && r_tick_pend) begin
                r_tick_pend <= 1'b0;
            end
            if (PERIOD != 0) begin
                if (r_pcnt == LP_PMAX) begin
                    r_pcnt      <= '0;
                    r_tick_pend <= 1'b1;
                end else begin
                    r_pcnt <= r_pcnt + 1'b1;
                end
            end
        end
    end

    assign o_clk_en = r_clk_en;
    assign o_ready  = r_ready;
    assign o_ack    = r_ack;
    assign o_tick   = r_tick;
    assign o_state  = r_state;

endmodule

// File: tb/tb_servant_power_sequencer.sv
// Bench for servant_power_sequencer: two instances (timer off / PERIOD=8)
// checked every cycle against a deadline-based model plus directed literals.
module tb_servant_power_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_a = 2'b00;
    logic [1:0] req_b = 2'b00;
    logic       frc_a = 1'b0;
    logic       frc_b = 1'b0;

    logic       en_a, rdy_a, tick_a;
    logic [1:0] ack_a;
    logic [2:0] st_a;
    logic       en_b, rdy_b, tick_b;
    logic [1:0] ack_b;
    logic [2:0] st_b;

    int total = 0;
    int bad   = 0;
    bit armed = 0;

    always #5 clk = ~clk;

    servant_power_sequencer #(
        .N_REQ(2), .CNT_W(16), .WAKE_CYCLES(2),
        .IDLE_TIMEOUT(16), .COOL_CYCLES(1), .PERIOD(0)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_req(req_a), .i_force_on(frc_a),
        .o_clk_en(en_a), .o_ready(rdy_a), .o_ack(ack_a),
        .o_tick(tick_a), .o_state(st_a)
    );

    servant_power_sequencer #(
        .N_REQ(2), .CNT_W(16), .WAKE_CYCLES(2),
        .IDLE_TIMEOUT(16), .COOL_CYCLES(1), .PERIOD(8)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_req(req_b), .i_force_on(frc_b),
        .o_clk_en(en_b), .o_ready(rdy_b), .o_ack(ack_b),
        .o_tick(tick_b), .o_state(st_b)
    );

    // Model: phase plus absolute-cycle deadlines, inputs seen 2 edges late.
    typedef struct {
        int         cyc;
        int         st;
        int         wake_done;
        int         idle_exp;
        int         cool_done;
        bit         pend;
        logic [1:0] s1;
        logic [1:0] rs;
        logic       f1;
        logic       fs;
        logic       en;
        logic       rdy;
        logic       tick;
        logic [1:0] ack;
    } mdl_t;

    function automatic mdl_t mreset();
        mdl_t m;
        m.cyc = 0; m.st = 0; m.wake_done = 0; m.idle_exp = 0;
        m.cool_done = 0; m.pend = 0; m.s1 = 0; m.rs = 0;
        m.f1 = 0; m.fs = 0; m.en = 0; m.rdy = 0; m.tick = 0; m.ack = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, logic [1:0] rq, logic fo,
                                   int wk, int it, int cl, int per);
        mdl_t n;
        bit   any;
        int   nx;
        n      = m;
        any    = (m.rs != 2'b00) || m.fs || m.pend;
        nx     = m.cyc + 1;
        n.cyc  = nx;
        n.tick = 0;
        n.ack  = 2'b00;
        if (m.st == 0) begin
            if (any) begin
                n.st = 1;
                n.wake_done = nx + wk;
            end
        end else if (m.st == 1) begin
            if (nx == m.wake_done) n.st = 2;
        end else if (m.st == 2) begin
            n.ack = m.rs;
            if (m.pend) begin
                n.tick = 1;
                n.pend = 0;
            end
            if (!any) begin
                n.st = 3;
                n.idle_exp = nx + it;
            end
        end else if (m.st == 3) begin
            if (any) begin
                n.st = 2;
                n.ack = m.rs;
            end else if (nx == m.idle_exp) begin
                n.st = 4;
                n.cool_done = nx + cl;
            end
        end else begin
            if (nx == m.cool_done) n.st = 0;
        end
        if (per > 0 && (nx % per) == 0) n.pend = 1;
        n.en  = (n.st >= 1 && n.st <= 3);
        n.rdy = (n.st == 2 || n.st == 3);
        n.rs  = m.s1;
        n.s1  = rq;
        n.fs  = m.f1;
        n.f1  = fo;
        return n;
    endfunction

    mdl_t ma, mb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ma <= mreset();
            mb <= mreset();
        end else begin
            ma <= mstep(ma, req_a, frc_a, 2, 16, 1, 0);
            mb <= mstep(mb, req_b, frc_b, 2, 16, 1, 8);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("model_a", {24'd0, en_a, rdy_a, tick_a, ack_a, st_a},
                {24'd0, ma.en, ma.rdy, ma.tick, ma.ack, 3'(ma.st)});
            chk("model_b", {24'd0, en_b, rdy_b, tick_b, ack_b, st_b},
                {24'd0, mb.en, mb.rdy, mb.tick, mb.ack, 3'(mb.st)});
        end
    end

    task automatic step1();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) step1();
        rst = 1'b0;
    endtask

    task automatic wait_st(input int s, input int lim, input string nm);
        int n;
        n = 0;
        while (st_a !== 3'(s) && n < lim) begin
            step1();
            n++;
        end
        chk(nm, st_a, s);
    endtask

    int  gap, idle_n;
    bit  saw_ack, saw_cool, en_low;

    initial begin
        repeat (3) step1();
        armed = 1;
        chk("rst_en", en_a, 0);
        chk("rst_state", st_a, 0);
        chk("rst_outs", {rdy_a, tick_a, ack_a}, 0);
        rst = 1'b0;

        // Periodic wake on instance B, no requests.
        for (int c = 1; c <= 19; c++) begin
            step1();
            if (c == 8)  chk("per_en_c8", en_b, 0);
            if (c == 9)  chk("per_en_c9", en_b, 1);
            if (c == 11) chk("per_tick_c11", tick_b, 0);
            if (c == 12) chk("per_tick_c12", tick_b, 1);
            if (c == 12) chk("per_mdl_c12", mb.tick, 1);
            if (c == 13) chk("per_tick_c13", tick_b, 0);
            if (c == 18) chk("per_tick_c18", tick_b, 1);
        end

        // Single request latency.
        do_reset();
        req_a = 2'b01;
        for (int c = 1; c <= 8; c++) begin
            step1();
            if (c == 2) chk("lat_en_c2", en_a, 0);
            if (c == 3) chk("lat_en_c3", en_a, 1);
            if (c == 4) chk("lat_rdy_c4", rdy_a, 0);
            if (c == 5) chk("lat_rdy_c5", rdy_a, 1);
            if (c == 5) chk("lat_ack_c5", ack_a, 0);
            if (c == 6) chk("lat_ack_c6", ack_a, 1);
            if (c == 6) chk("lat_mdl_c6", ma.ack, 1);
        end
        req_a = 2'b00;
        wait_st(0, 60, "back_off");

        // Request dropped during WAKE.
        req_a = 2'b01;
        repeat (3) step1();
        req_a = 2'b00;
        saw_ack = 0; saw_cool = 0; idle_n = 0;
        for (int c = 0; c < 40; c++) begin
            step1();
            if (ack_a != 0) saw_ack = 1;
            if (st_a == 3'd4) saw_cool = 1;
            if (st_a == 3'd3) idle_n++;
        end
        chk("drop_no_ack", saw_ack, 0);
        chk("drop_cool", saw_cool, 1);
        chk("drop_idle_len", idle_n, 16);
        chk("drop_off", st_a, 0);

        // Re-request in IDLE (10th idle cycle).
        req_a = 2'b01;
        wait_st(2, 10, "rq_on");
        repeat (3) step1();
        req_a = 2'b00;
        wait_st(3, 10, "rq_idle");
        repeat (9) step1();
        req_a = 2'b01;
        en_low = 0;
        for (int c = 0; c < 8; c++) begin
            step1();
            if (!en_a) en_low = 1;
        end
        chk("idle_en_held", en_low, 0);
        chk("idle_back_on", st_a, 2);
        chk("idle_ack", ack_a, 1);

        // Re-request in COOL.
        req_a = 2'b00;
        wait_st(4, 40, "rq_cool");
        req_a = 2'b01;
        gap = 0;
        for (int n = 0; n < 20 && st_a !== 3'd1; n++) begin
            if (!en_a) gap++;
            step1();
        end
        chk("cool_rewake", st_a, 1);
        chk("cool_gap", gap, 3);

        // Reset while in WAKE.
        req_a = 2'b00;
        wait_st(0, 60, "pre_rst_off");
        req_a = 2'b01;
        wait_st(1, 10, "pre_rst_wake");
        rst = 1'b1;
        #1;
        chk("midrst_en", en_a, 0);
        chk("midrst_state", st_a, 0);
        req_a = 2'b00;
        repeat (2) step1();
        rst = 1'b0;
        saw_ack = 0;
        for (int c = 0; c < 12; c++) begin
            step1();
            if (ack_a != 0) saw_ack = 1;
        end
        chk("midrst_no_ack", saw_ack, 0);

        // Two requesters and force across an idle window.
        req_a = 2'b01;
        repeat (2) step1();
        req_a = 2'b11;
        repeat (8) step1();
        chk("two_ack_11", ack_a, 3);
        req_a = 2'b10;
        repeat (4) step1();
        chk("two_ack_10", ack_a, 2);
        req_a = 2'b00;
        wait_st(3, 10, "frc_idle");
        frc_a = 1'b1;
        saw_cool = 0; saw_ack = 0;
        for (int c = 0; c < 40; c++) begin
            step1();
            if (st_a == 3'd4) saw_cool = 1;
            if (ack_a != 0) saw_ack = 1;
        end
        chk("frc_no_cool", saw_cool, 0);
        chk("frc_no_ack", saw_ack, 0);
        frc_a = 1'b0;

        // Randomised traffic on both instances.
        for (int c = 0; c < 2500; c++) begin
            step1();
            if ($urandom_range(15) == 0) req_a[0] = ~req_a[0];
            if ($urandom_range(15) == 0) req_a[1] = ~req_a[1];
            if ($urandom_range(19) == 0) req_b[0] = ~req_b[0];
            if ($urandom_range(19) == 0) req_b[1] = ~req_b[1];
            if ($urandom_range(59) == 0) frc_a = ~frc_a;
            if ($urandom_range(59) == 0) frc_b = ~frc_b;
        end
        req_a = 0; req_b = 0; frc_a = 0; frc_b = 0;
        repeat (40) step1();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
